// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - FIFO-buffered (X,Y,Z) job issuer driving the accelerator start/done handshake
// Optional feature macro: DISPATCH_TIMEOUT_EN (abort WAIT after TIMEOUT cycles, sticky timeout_err).
module job_dispatcher #(
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 10,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [8:0]  job_x,
    input  logic [8:0]  job_y,
    input  logic [8:0]  job_z,
    output logic        start,
    output logic [8:0]  X,
    output logic [8:0]  Y,
    output logic [8:0]  Z,
    input  logic        done,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result_cycles,
    output logic        timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam logic [SW-1:0] START_LAST  = SW'(START_CYCLES - 1);
    localparam logic [15:0]   TIMEOUT_CNT = 16'(TIMEOUT);
`ifdef DISPATCH_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [26:0]   fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          start_q, start_d;
    logic [8:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [8:0]    z_q, z_d;
    logic          busy_q, busy_d;
    logic          rvalid_q, rvalid_d;
    logic [15:0]   rcycles_q, rcycles_d;
    logic          timeout_q, timeout_d;

    logic          full;
    logic          empty;
    logic          push;
    logic [26:0]   head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = job_valid && !full;
    assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {job_x, job_y, job_z};
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        scnt_d    = scnt_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        rvalid_d  = 1'b0;
        rcycles_d = rcycles_q;
        timeout_d = timeout_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    x_d      = head[26:18];
                    y_d      = head[17:9];
                    z_d      = head[8:0];
                    start_d  = 1'b1;
                    scnt_d   = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                // done is deliberately ignored while the accelerator is initialising.
                if (scnt_q == START_LAST) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (done) begin
                    rvalid_d  = 1'b1;
                    rcycles_d = cnt_q;
                    state_d   = S_RELEASE;
                end else if (TIMEOUT_ON && (cnt_q == TIMEOUT_CNT)) begin
                    rvalid_d  = 1'b1;
                    rcycles_d = TIMEOUT_CNT;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RELEASE: begin
                if (!done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            scnt_q    <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            busy_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rcycles_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            scnt_q    <= scnt_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            busy_q    <= busy_d;
            rvalid_q  <= rvalid_d;
            rcycles_q <= rcycles_d;
            timeout_q <= timeout_d;
        end
    end

    assign job_ready     = !full;
    assign start         = start_q;
    assign X             = x_q;
    assign Y             = y_q;
    assign Z             = z_q;
    assign busy          = busy_q;
    assign result_valid  = rvalid_q;
    assign result_cycles = rcycles_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_job_dispatcher.sv
// tb/tb_job_dispatcher.sv - directed and randomized checks of job_dispatcher against a queue-based accelerator model
module tb_job_dispatcher;
    localparam int DEPTH = 4;
    localparam int SC    = 10;
    localparam int TO    = 100;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [8:0]  job_x = '0;
    logic [8:0]  job_y = '0;
    logic [8:0]  job_z = '0;
    logic        start;
    logic [8:0]  X, Y, Z;
    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    logic        done;
    logic        busy, result_valid, timeout_err;
    logic [15:0] result_cycles;

    assign done = model_done | force_done;
    always #5 clk = ~clk;

    job_dispatcher #(.DEPTH(DEPTH), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_z(job_z), .start(start),
        .X(X), .Y(Y), .Z(Z), .done(done), .busy(busy),
        .result_valid(result_valid), .result_cycles(result_cycles), .timeout_err(timeout_err)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int          delay_q[$];
    int          hold_q[$];
    bit          glitch_q[$];
    logic [26:0] issued_q[$];
    int          width_q[$];
    int          res_q[$];
    int          start_while_done = 0;
    int          xyz_changes = 0;

    // Accelerator model: done rises <delay> cycles after start falls, stays high <hold> cycles.
    bit m_prev, m_armed;
    int m_cnt, m_delay, m_hold, m_hold_left, m_glitch_left;
    always @(negedge clk) begin
        if (!rst_n) begin
            model_done = 1'b0; m_prev = 0; m_armed = 0; m_hold_left = 0; m_glitch_left = 0;
        end else begin
            if (start && !m_prev) begin
                if (done) start_while_done++;
                m_delay = (delay_q.size() > 0) ? delay_q.pop_front() : -1;
                m_hold  = (hold_q.size() > 0) ? hold_q.pop_front() : 1;
                m_glitch_left = ((glitch_q.size() > 0) ? glitch_q.pop_front() : 1'b0) ? 2 : 0;
                m_armed = 0;
            end
            if (!start && m_prev) begin
                m_armed = 1; m_cnt = 0;
            end else if (m_armed) begin
                m_cnt++;
            end
            if (m_glitch_left > 0) begin
                model_done = 1'b1; m_glitch_left--;
            end else if (m_armed && m_delay >= 0 && m_cnt == m_delay) begin
                model_done = 1'b1; m_armed = 0; m_hold_left = m_hold - 1;
            end else if (m_hold_left > 0) begin
                m_hold_left--;
            end else begin
                model_done = 1'b0;
            end
            m_prev = start;
        end
    end

    bit          mon_prev;
    int          mon_width;
    logic [26:0] mon_cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = 0; mon_width = 0; mon_cur = '0;
        end else begin
            if (start) begin
                if (!mon_prev) begin
                    mon_cur = {X, Y, Z};
                    issued_q.push_back(mon_cur);
                end
                mon_width++;
            end else if (mon_prev) begin
                width_q.push_back(mon_width);
                mon_width = 0;
            end
            if (busy && ({X, Y, Z} !== mon_cur)) xyz_changes++;
            if (result_valid) res_q.push_back(int'(result_cycles));
            mon_prev = start;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic plan(input int d, input int h, input bit g);
        delay_q.push_back(d);
        hold_q.push_back(h);
        glitch_q.push_back(g);
    endtask

    task automatic push_job(input logic [8:0] x, input logic [8:0] y, input logic [8:0] z);
        bit taken = 0;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            job_valid = 1'b1; job_x = x; job_y = y; job_z = z;
            taken = job_ready;
            @(posedge clk);
            #1;
        end
        job_valid = 1'b0;
        check("push_accepted", taken, 1);
    endtask

    task automatic wait_results(input int n, input int budget);
        int i = 0;
        while (res_q.size() < n && i < budget) begin tick(); i++; end
        check("results_arrive", res_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin tick(); i++; end
        check("reach_idle", busy, 0);
    endtask

    task automatic wait_in_wait(input int budget);
        int i = 0;
        while (!(busy && !start) && i < budget) begin tick(); i++; end
        check("reach_wait", busy && !start, 1);
    endtask

    task automatic clear_all();
        issued_q.delete(); width_q.delete(); res_q.delete();
        delay_q.delete(); hold_q.delete(); glitch_q.delete();
    endtask

    logic [26:0] exp_job[$];
    int          exp_res[$];
    logic [8:0]  rx, ry, rz;
    int          rd;
    bit          seen;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_start", start, 0);
        check("rst_xyz", {X, Y, Z}, 0);
        check("rst_busy", busy, 0);
        check("rst_rvalid", result_valid, 0);
        check("rst_rcycles", result_cycles, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_ready", job_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single job, done 37 cycles after start falls
        plan(37, 3, 0);
        push_job(9'd16, 9'd0, 9'd0);
        wait_results(1, 300);
        wait_idle(50);
        repeat (5) tick();
        check("t1_nres", res_q.size(), 1);
        check("t1_cycles", res_q[0], 37);
        check("t1_width", width_q[0], SC);
        check("t1_xyz", issued_q[0], {9'd16, 9'd0, 9'd0});
        check("t1_hold_rc", result_cycles, 37);
        check("t1_hold_x", X, 16);
        clear_all();

        // done glitch inside START window is ignored
        plan(5, 2, 1);
        push_job(9'd3, 9'd4, 9'd5);
        wait_results(1, 200);
        wait_idle(50);
        check("t4_cycles", res_q[0], 5);
        check("t4_width", width_q[0], SC);
        clear_all();

        // Three queued jobs, done held 3 cycles each
        plan(0, 3, 0); plan(4, 3, 0); plan(9, 3, 0);
        push_job(9'd1, 9'd2, 9'd3);
        push_job(9'd11, 9'd12, 9'd13);
        push_job(9'd21, 9'd22, 9'd23);
        wait_results(3, 300);
        wait_idle(50);
        repeat (5) tick();
        check("t3_nres", res_q.size(), 3);
        check("t3_order0", issued_q[0], {9'd1, 9'd2, 9'd3});
        check("t3_order1", issued_q[1], {9'd11, 9'd12, 9'd13});
        check("t3_order2", issued_q[2], {9'd21, 9'd22, 9'd23});
        check("t3_res0", res_q[0], 0);
        check("t3_res1", res_q[1], 4);
        check("t3_res2", res_q[2], 9);
        clear_all();

        // Randomized jobs against the queue model
        for (int j = 0; j < 8; j++) begin
            rx = 9'($urandom_range(0, 511));
            ry = 9'($urandom_range(0, 511));
            rz = 9'($urandom_range(0, 511));
            rd = $urandom_range(0, 25);
            exp_job.push_back({rx, ry, rz});
            exp_res.push_back(rd);
            plan(rd, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            push_job(rx, ry, rz);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_results(8, 1500);
        wait_idle(50);
        check("rnd_nissued", issued_q.size(), 8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("rnd_job%0d", j), issued_q[j], exp_job[j]);
            check($sformatf("rnd_res%0d", j), res_q[j], exp_res[j]);
            check($sformatf("rnd_width%0d", j), width_q[j], SC);
        end
        check("no_start_while_done", start_while_done, 0);
        check("xyz_stable", xyz_changes, 0);
        clear_all();

        // Back-to-back pushes fill the FIFO; a further offer is held until a pop
        plan(-1, 1, 0);
        for (int j = 0; j < 5; j++) plan(2, 1, 0);
        for (int j = 1; j <= 5; j++) push_job(9'(j), 9'(j + 100), 9'(j + 200));
        tick();
        check("t2_full_ready", job_ready, 0);
        job_valid = 1'b1; job_x = 9'd6; job_y = 9'd106; job_z = 9'd206;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("t2_held", job_ready, 0);
        end
        check("t2_one_issued", issued_q.size(), 1);
        wait_in_wait(100);
        force_done = 1'b1;
        repeat (3) tick();
        force_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = job_ready;
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        check("t2_slot_freed", seen, 1);
        wait_results(6, 600);
        wait_idle(50);
        for (int j = 1; j <= 5; j++) begin
            check($sformatf("t2_order%0d", j), issued_q[j], {9'(j + 1), 9'(j + 101), 9'(j + 201)});
            check($sformatf("t2_res%0d", j), res_q[j], 2);
        end
        check("t2_no_start_while_done", start_while_done, 0);
        clear_all();

        // Timeout behaviour
`ifdef DISPATCH_TIMEOUT_EN
        plan(-1, 1, 0);
        plan(3, 2, 0);
        push_job(9'd7, 9'd8, 9'd9);
        push_job(9'd17, 9'd18, 9'd19);
        wait_results(2, 600);
        wait_idle(50);
        check("t5_to_cycles", res_q[0], TO);
        check("t5_to_flag", timeout_err, 1);
        check("t5_next_res", res_q[1], 3);
        check("t5_next_job", issued_q[1], {9'd17, 9'd18, 9'd19});
`else
        plan(-1, 1, 0);
        push_job(9'd7, 9'd8, 9'd9);
        repeat (300) tick();
        check("t5_busy_stays", busy, 1);
        check("t5_no_timeout", timeout_err, 0);
        check("t5_no_result", res_q.size(), 0);
`endif

        // Reset during WAIT with two jobs queued
        plan(-1, 1, 0); plan(-1, 1, 0); plan(-1, 1, 0);
        if (!busy) push_job(9'd31, 9'd32, 9'd33);
        push_job(9'd41, 9'd42, 9'd43);
        push_job(9'd51, 9'd52, 9'd53);
        wait_in_wait(100);
        repeat (5) tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_start", start, 0);
        check("t6_xyz", {X, Y, Z}, 0);
        check("t6_ready", job_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_timeout", timeout_err, 0);
        repeat (2) tick();
        clear_all();
        rst_n = 1'b1;
        repeat (20) tick();
        check("t6_fifo_empty", issued_q.size(), 0);
        check("t6_idle", busy, 0);
        check("t6_ready_after", job_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
